// File: rtl/bool_seq_unit_pkg.sv
// Shared definitions for the multi-cycle Boolean unit.
// Holds the truth-table encodings for fn, the FSM state encodings and a
// one-bit truth-table lookup helper.
package bool_seq_unit_pkg;

   // Truth-table encodings: result bit = fn[{a_bit, b_bit}]
   localparam logic [3:0] BOOL_FN_AND  = 4'b1000;
   localparam logic [3:0] BOOL_FN_OR   = 4'b1110;
   localparam logic [3:0] BOOL_FN_XOR  = 4'b0110;
   localparam logic [3:0] BOOL_FN_XNOR = 4'b1001;
   localparam logic [3:0] BOOL_FN_A    = 4'b1100;
   localparam logic [3:0] BOOL_FN_B    = 4'b1010;
   localparam logic [3:0] BOOL_FN_ZERO = 4'b0000;
   localparam logic [3:0] BOOL_FN_ONES = 4'b1111;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Look up one result bit in a 4-entry truth table
   function automatic logic boolBit(input logic [3:0] fnTable,
                                    input logic       aBit,
                                    input logic       bBit);
      return fnTable[{aBit, bBit}];
   endfunction

endpackage

// File: rtl/bool_seq_unit_slice.sv
// Combinational slice of the Boolean unit: applies the 4-bit truth table
// to every bit pair of one SLICE-wide chunk of the captured operands.
module bool_seq_unit_slice
   import bool_seq_unit_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic [3:0]       i_fn,
   output logic [SLICE-1:0] o_y
);

   // Each bit independently indexes the truth table with its {a, b} pair
   always_comb begin
      o_y = '0;
      for (int i = 0; i < SLICE; i++) begin
         o_y[i] = boolBit(i_fn, i_a[i], i_b[i]);
      end
   end

endmodule

// File: rtl/bool_seq_unit.sv
// Multi-cycle bitwise Boolean unit with valid/ready handshakes on both sides.
// Computes out = f(a, b) for any 2-input function given as a 4-bit truth
// table, SLICE bits per cycle, LSB slice first.
// Optional feature: define BOOL_ZERO_FLAG_EN to add the registered zero flag z.
module bool_seq_unit
   import bool_seq_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       fn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
`ifdef BOOL_ZERO_FLAG_EN
   ,
   output logic             z
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_fn;
   logic [WIDTH-1:0] r_out;

   logic [31:0]      w_base;
   logic [SLICE-1:0] w_aSlice;
   logic [SLICE-1:0] w_bSlice;
   logic [SLICE-1:0] w_ySlice;

   // Bit offset of the slice being worked on this cycle
   assign w_base   = 32'(r_cnt) * 32'(SLICE);
   assign w_aSlice = r_a[w_base +: SLICE];
   assign w_bSlice = r_b[w_base +: SLICE];

   bool_seq_unit_slice #(.SLICE(SLICE)) u_slice (
      .i_a  (w_aSlice),
      .i_b  (w_bSlice),
      .i_fn (r_fn),
      .o_y  (w_ySlice)
   );

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
   assign out       = r_out;

`ifdef BOOL_ZERO_FLAG_EN
   logic r_z;
   logic r_zAcc;
   logic w_zNext;

   assign w_zNext = r_zAcc & (w_ySlice == '0);
   assign z       = r_z;

   // Zero flag: accumulates "all slices so far are zero" while running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z    <= 1'b0;
         r_zAcc <= 1'b0;
      end else if (r_state == ST_IDLE && in_valid) begin
         r_z    <= 1'b0;
         r_zAcc <= 1'b1;
      end else if (r_state == ST_RUN) begin
         r_z    <= w_zNext;
         r_zAcc <= w_zNext;
      end
   end
`endif

   // Control FSM plus operand capture and slice-by-slice result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_fn    <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_fn    <= fn;
                  r_out   <= '0;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_out[w_base +: SLICE] <= w_ySlice;
               if (r_cnt == LAST_CNT) begin
                  r_cnt   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bool_seq_unit.sv
// Testbench for bool_seq_unit: table-driven vectors, hand-written corner
// sequences and randomized operations checked against a minterm-sum model.
// A second instance with SLICE == WIDTH covers the single-cycle RUN build.
module tb_bool_seq_unit;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [3:0]       fn = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out;
   logic             busy;

   logic             wideInReady;
   logic             wideOutValid;
   logic [WIDTH-1:0] wideOut;
   logic             wideBusy;
`ifdef BOOL_ZERO_FLAG_EN
   logic             z;
   logic             wideZ;
`endif

   int numCompared   = 0;
   int numMismatched = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  fn;
      logic [31:0] expOut;
      string       name;
   } vec_t;

   vec_t vecs[10];

   bool_seq_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .fn        (fn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
`ifdef BOOL_ZERO_FLAG_EN
      ,
      .z         (z)
`endif
   );

   bool_seq_unit #(.WIDTH(WIDTH), .SLICE(WIDTH)) u_dutWide (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (wideInReady),
      .a         (a),
      .b         (b),
      .fn        (fn),
      .out_valid (wideOutValid),
      .out_ready (out_ready),
      .out       (wideOut),
      .busy      (wideBusy)
`ifdef BOOL_ZERO_FLAG_EN
      ,
      .z         (wideZ)
`endif
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Reference: OR together the minterms the truth table selects
   function automatic logic [31:0] refBool(input logic [31:0] ra,
                                           input logic [31:0] rb,
                                           input logic [3:0]  rfn);
      logic [31:0] r;
      r = '0;
      if (rfn[3]) r = r | (ra & rb);
      if (rfn[2]) r = r | (ra & ~rb);
      if (rfn[1]) r = r | (~ra & rb);
      if (rfn[0]) r = r | (~ra & ~rb);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One full operation: accept, wait for result, optional backpressure, release
   task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                input logic [3:0] vfn, input logic [31:0] expOut,
                                input int hold, input bit scramble, input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
      a        = va;
      b        = vb;
      fn       = vfn;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = scramble ? $urandom : 32'd0;
      b        = scramble ? $urandom : 32'd0;
      fn       = scramble ? 4'($urandom) : 4'd0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " latency"}, 32'(n), 32'(NSLICE));
      checkOutput({name, " out"}, out, expOut);
`ifdef BOOL_ZERO_FLAG_EN
      checkOutput({name, " z"}, 32'(z), 32'(expOut == 32'd0));
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         fn       = 4'($urandom);
         @(negedge clk);
         checkOutput({name, " held out"}, out, expOut);
         checkOutput({name, " held out_valid"}, 32'(out_valid), 32'd1);
         checkOutput({name, " held in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({name, " in_ready after release"}, 32'(in_ready), 32'd1);
      checkOutput({name, " out_valid after release"}, 32'(out_valid), 32'd0);
      checkOutput({name, " out kept in idle"}, out, expOut);
   endtask

   initial begin
      vecs[0] = '{32'he9eec208, 32'h583bd1cc, 4'b1110, 32'hf9ffd3cc, "OR basic"};
      vecs[1] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1000, 32'hFF000000, "AND"};
      vecs[2] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1110, 32'hFFFFFF00, "OR"};
      vecs[3] = '{32'hFFFF0000, 32'hFF00FF00, 4'b0110, 32'h00FFFF00, "XOR"};
      vecs[4] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1001, 32'hFF0000FF, "XNOR"};
      vecs[5] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1100, 32'hFFFF0000, "PASS A"};
      vecs[6] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1010, 32'hFF00FF00, "PASS B"};
      vecs[7] = '{32'hFFFF0000, 32'hFF00FF00, 4'b0000, 32'h00000000, "ZERO"};
      vecs[8] = '{32'hFFFF0000, 32'hFF00FF00, 4'b1111, 32'hFFFFFFFF, "ONES"};
      vecs[9] = '{32'h1fbc8148, 32'h20ce01ee, 4'b1110, 32'h3ffe81ee, "OR operands zeroed"};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset out", out, 32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle in_ready", 32'(in_ready), 32'd1);
      checkOutput("idle out", out, 32'd0);
      checkOutput("idle out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle busy", 32'(busy), 32'd0);

      // Single-slice build: both instances take the same op, wide one is 1 cycle
      begin
         int n;
         a        = 32'he9eec208;
         b        = 32'h583bd1cc;
         fn       = 4'b1110;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         a        = '0;
         b        = '0;
         checkOutput("narrow busy after accept", 32'(busy), 32'd1);
         n = 0;
         while (!wideOutValid && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("wide latency", 32'(n), 32'd1);
         checkOutput("wide out", wideOut, 32'hf9ffd3cc);
         checkOutput("wide in_ready in DONE", 32'(wideInReady), 32'd0);
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("narrow latency beside wide", 32'(n), 32'(NSLICE));
         checkOutput("narrow out beside wide", out, 32'hf9ffd3cc);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         checkOutput("wide back to idle", 32'(wideInReady), 32'd1);
         checkOutput("narrow back to idle", 32'(in_ready), 32'd1);
      end

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fn, vecs[i].expOut, 0, 1'b0,
                       vecs[i].name);
      end

      // Backpressure: five cycles held in DONE with new requests ignored
      applyStimulus(32'h12345678, 32'h0f0f0f0f, 4'b0110, 32'h1d3b5977, 5, 1'b0,
                    "backpressure");

      // Reset mid-RUN: partial result visible, then abandoned
      begin
         bit sawValid;
         a        = 32'hA5A5A5A5;
         b        = 32'h0F0F0F0F;
         fn       = 4'b1000;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (2) @(negedge clk);
         checkOutput("partial out mid-RUN", out, 32'h00000505);
         rst_n = 1'b0;
         #1;
         checkOutput("mid-RUN reset out", out, 32'd0);
         checkOutput("mid-RUN reset busy", 32'(busy), 32'd0);
         @(negedge clk);
         rst_n    = 1'b1;
         sawValid = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
         end
         checkOutput("no out_valid after reset", 32'(sawValid), 32'd0);
         checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
         checkOutput("busy after reset", 32'(busy), 32'd0);
      end

      // Randomized ops against the reference model
      for (int i = 0; i < 20; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [3:0]  rfn;
         ra  = $urandom;
         rb  = $urandom;
         rfn = 4'($urandom);
         applyStimulus(ra, rb, rfn, refBool(ra, rb, rfn), int'($urandom_range(0, 3)),
                       1'b1, $sformatf("random %0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
